// File: rtl/mips86_mem_pkg.sv
// Shared definitions for the single-port memory arbiter of the dataflow core.
package mips86_mem_pkg;

  localparam int unsigned DEFAULT_BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_t;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational winner pick: data first, fetch once the data burst is exhausted.
module arb_priority_select
  import mips86_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned STREAK_W       = 3
) (
  input  logic                fReq,
  input  logic                dReq,
  input  logic [STREAK_W-1:0] dataStreak,
  output logic                grantValid_c,
  output logic                grantPort_c
);

  always_comb begin
    grantValid_c = fReq | dReq;
    grantPort_c  = PORT_DATA;
    if (fReq && (!dReq || dataStreak == STREAK_W'(MAX_DATA_BURST))) begin
      grantPort_c = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MMU port between instruction fetch and data accesses, one
// transaction at a time, with a bounded data burst and a busy watchdog.
module mem_port_arbiter
  import mips86_mem_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = DEFAULT_BUS_WIDTH,
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic [BUS_WIDTH-1:0] f_addr,
  output logic                 f_busy,
  output logic                 f_done,
  output logic                 f_err,
  output logic [BUS_WIDTH-1:0] f_rdata,
  input  logic                 d_req,
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic                 d_we,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  output logic                 d_busy,
  output logic                 d_done,
  output logic                 d_err,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic                 mem_request,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic                 mem_busy
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_BURST + 1);
  localparam int unsigned WDOG_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t          state, stateNext;
  port_id_t            grantPort, grantPortNext;
  logic [STREAK_W-1:0] dataStreak, streakNext;
  logic [WDOG_W-1:0]   wdogCnt, wdogNext;
  logic                fReqQ, dReqQ;

  logic                 fBusyNext, dBusyNext, fDoneNext, dDoneNext, fErrNext, dErrNext;
  logic                 memReqNext, memWeNext;
  logic [BUS_WIDTH-1:0] memAddrNext, memWdataNext, fRdataNext, dRdataNext;

  logic fNew_c, dNew_c, fPend_c, dPend_c, grantValid_c, grantPortSel_c, timeoutHit_c;
  logic completeNow_c;
  logic [BUS_WIDTH-1:0] completeData_c;

  // A request is taken on its rising edge only, and never in its own done cycle.
  assign fNew_c  = f_req & ~fReqQ & ~f_done;
  assign dNew_c  = d_req & ~dReqQ & ~d_done;
  assign fPend_c = f_busy | fNew_c;
  assign dPend_c = d_busy | dNew_c;

  // wdogCnt counts busy WAIT samples since issue.
  assign timeoutHit_c = (TIMEOUT != 0) && (wdogCnt == WDOG_W'(TIMEOUT));

  arb_priority_select #(
    .MAX_DATA_BURST (MAX_DATA_BURST),
    .STREAK_W       (STREAK_W)
  ) uPrioritySelect (
    .fReq         (fPend_c),
    .dReq         (dPend_c),
    .dataStreak   (dataStreak),
    .grantValid_c (grantValid_c),
    .grantPort_c  (grantPortSel_c)
  );

  always_comb begin
    stateNext      = state;
    grantPortNext  = grantPort;
    streakNext     = dataStreak;
    wdogNext       = wdogCnt;
    memAddrNext    = mem_addr;
    memReqNext     = mem_request;
    memWeNext      = mem_we;
    memWdataNext   = mem_wdata;
    fBusyNext      = fPend_c;
    dBusyNext      = dPend_c;
    fDoneNext      = 1'b0;
    dDoneNext      = 1'b0;
    fErrNext       = 1'b0;
    dErrNext       = 1'b0;
    fRdataNext     = f_rdata;
    dRdataNext     = d_rdata;
    completeNow_c  = 1'b0;
    completeData_c = mem_rdata;

    case (state)
      IDLE: begin
        // No grant in a done cycle, so a just-finished requester can re-raise and compete.
        if (grantValid_c && !f_done && !d_done) begin
          stateNext     = ISSUE;
          grantPortNext = port_id_t'(grantPortSel_c);
          memReqNext    = 1'b1;
          if (port_id_t'(grantPortSel_c) == PORT_DATA) begin
            memAddrNext  = d_addr;
            memWeNext    = d_we;
            memWdataNext = d_wdata;
            if (dataStreak != STREAK_W'(MAX_DATA_BURST)) begin
              streakNext = dataStreak + STREAK_W'(1);
            end
          end else begin
            memAddrNext  = f_addr;
            memWeNext    = 1'b0;
            memWdataNext = '0;
            streakNext   = '0;
          end
        end
      end
      ISSUE: begin
        wdogNext  = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        if (!mem_busy) begin
          completeNow_c = 1'b1;
        end else if (timeoutHit_c) begin
          completeNow_c  = 1'b1;
          completeData_c = '0;
        end else if (TIMEOUT != 0) begin
          wdogNext = wdogCnt + WDOG_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    if (completeNow_c) begin
      stateNext  = IDLE;
      memReqNext = 1'b0;
      memWeNext  = 1'b0;
      if (grantPort == PORT_DATA) begin
        dDoneNext  = 1'b1;
        dErrNext   = mem_busy;
        dRdataNext = completeData_c;
        dBusyNext  = 1'b0;
      end else begin
        fDoneNext  = 1'b1;
        fErrNext   = mem_busy;
        fRdataNext = completeData_c;
        fBusyNext  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      grantPort   <= PORT_FETCH;
      dataStreak  <= '0;
      wdogCnt     <= '0;
      fReqQ       <= 1'b0;
      dReqQ       <= 1'b0;
      mem_addr    <= '0;
      mem_request <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      f_busy      <= 1'b0;
      d_busy      <= 1'b0;
      f_done      <= 1'b0;
      d_done      <= 1'b0;
      f_err       <= 1'b0;
      d_err       <= 1'b0;
      f_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state       <= stateNext;
      grantPort   <= grantPortNext;
      dataStreak  <= streakNext;
      wdogCnt     <= wdogNext;
      fReqQ       <= f_req;
      dReqQ       <= d_req;
      mem_addr    <= memAddrNext;
      mem_request <= memReqNext;
      mem_we      <= memWeNext;
      mem_wdata   <= memWdataNext;
      f_busy      <= fBusyNext;
      d_busy      <= dBusyNext;
      f_done      <= fDoneNext;
      d_done      <= dDoneNext;
      f_err       <= fErrNext;
      d_err       <= dErrNext;
      f_rdata     <= fRdataNext;
      d_rdata     <= dRdataNext;
    end
  end

endmodule
